// File: rtl/conv_core_pkg.sv
// Shared types and defaults for the con convolution core and its result-side collector.
package conv_core_pkg;

    localparam int unsigned OUT_W_DEF   = 32;
    localparam int unsigned PKT_LEN_DEF = 10;
    localparam int unsigned DEPTH_DEF   = 8;
    localparam int unsigned PKT_CNT_W   = 16;

    typedef enum logic {IDLE, FILL} coll_state_t;

    // Counter width that stays legal when the count range collapses to a single value.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/conv_out_fifo.sv
// Synchronous FIFO with a registered head entry; dout/empty/full/level are all flops.
module conv_out_fifo #(
    parameter int unsigned W     = 33,
    parameter int unsigned DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [W-1:0]             din,
    output logic [W-1:0]             dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned LW = AW + 1;

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;

    logic [AW-1:0] head_idx_c;
    logic [LW-1:0] level_nxt_c;
    logic          head_from_din_c;

    // Next head comes from the incoming word only when nothing older survives this cycle.
    always_comb begin
        head_idx_c      = rd_ptr + AW'(pop);
        level_nxt_c     = level + LW'(push) - LW'(pop);
        head_from_din_c = push && (level == (pop ? LW'(1) : LW'(0)));
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
            dout   <= '0;
            empty  <= 1'b1;
            full   <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            level <= level_nxt_c;
            empty <= (level_nxt_c == LW'(0));
            full  <= (level_nxt_c == LW'(DEPTH));
            if (level_nxt_c != LW'(0)) begin
                dout <= head_from_din_c ? din : mem[head_idx_c];
            end
        end
    end

endmodule

// File: rtl/conv_out_collector.sv
// Collects con core results, tags packet position, buffers them and streams them out.
module conv_out_collector
    import conv_core_pkg::*;
#(
    parameter int unsigned OUT_W   = OUT_W_DEF,
    parameter int unsigned DEPTH   = DEPTH_DEF,
    parameter int unsigned PKT_LEN = PKT_LEN_DEF
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    input  logic [OUT_W-1:0]        in_data,
    output logic                    m_valid,
    input  logic                    m_ready,
    output logic [OUT_W-1:0]        m_data,
    output logic                    m_last,
    output logic [$clog2(DEPTH):0]  level,
    output logic [PKT_CNT_W-1:0]    pkt_cnt,
    output logic                    overflow
);

    localparam int unsigned BEAT_W = cnt_width(PKT_LEN);

    typedef struct packed {
        logic             last;
        logic [OUT_W-1:0] data;
    } coll_entry_t;

    coll_state_t       state;
    logic [BEAT_W-1:0] beat;
    logic              fifo_full;
    logic              fifo_empty;
    logic              push_c;
    logic              pop_c;
    logic              drop_c;
    coll_entry_t       wr_ent_c;
    coll_entry_t       rd_ent;

    // A full FIFO still accepts a result when the head leaves in the same cycle.
    always_comb begin
        pop_c         = m_valid && m_ready;
        push_c        = in_valid && (!fifo_full || pop_c);
        drop_c        = in_valid && fifo_full && !pop_c;
        wr_ent_c.last = (beat == BEAT_W'(PKT_LEN - 1));
        wr_ent_c.data = in_data;
    end

    assign m_valid = !fifo_empty;
    assign m_data  = rd_ent.data;
    assign m_last  = rd_ent.last;

    conv_out_fifo #(
        .W     ($bits(coll_entry_t)),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push_c),
        .pop   (pop_c),
        .din   (wr_ent_c),
        .dout  (rd_ent),
        .full  (fifo_full),
        .empty (fifo_empty),
        .level (level)
    );

    // Packet phase: beat advances on every result, dropped or not, so tags stay aligned.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            beat  <= '0;
        end else if (in_valid) begin
            case (state)
                IDLE: begin
                    if (PKT_LEN > 1) begin
                        state <= FILL;
                        beat  <= BEAT_W'(1);
                    end
                end
                FILL: begin
                    if (beat == BEAT_W'(PKT_LEN - 1)) begin
                        state <= IDLE;
                        beat  <= '0;
                    end else begin
                        beat <= beat + BEAT_W'(1);
                    end
                end
                default: begin
                    state <= IDLE;
                    beat  <= '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pkt_cnt  <= '0;
            overflow <= 1'b0;
        end else begin
            if (pop_c && m_last) begin
                pkt_cnt <= pkt_cnt + PKT_CNT_W'(1);
            end
            if (drop_c) begin
                overflow <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_conv_out_collector.sv
// Scoreboard bench for conv_out_collector: expected entries queued at drive time, checked on pop.
module tb_conv_out_collector;

    localparam int unsigned DW      = 32;
    localparam int unsigned DEPTH   = 8;
    localparam int unsigned PKT_LEN = 10;

    typedef struct packed {
        logic          last;
        logic [DW-1:0] data;
    } tb_ent_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic [DW-1:0] in_data;
    logic          m_valid;
    logic          m_ready;
    logic [DW-1:0] m_data;
    logic          m_last;
    logic [3:0]    level;
    logic [15:0]   pkt_cnt;
    logic          overflow;

    tb_ent_t     sb[$];
    int          m_beat;
    logic [15:0] m_pkt;
    logic        m_ovf;
    int          vec_cnt;
    int          err_cnt;
    logic        ev;
    tb_ent_t     eh;

    always #5 clk = ~clk;

    conv_out_collector #(.OUT_W(DW), .DEPTH(DEPTH), .PKT_LEN(PKT_LEN)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_data  (in_data),
        .m_valid  (m_valid),
        .m_ready  (m_ready),
        .m_data   (m_data),
        .m_last   (m_last),
        .level    (level),
        .pkt_cnt  (pkt_cnt),
        .overflow (overflow)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_clear();
        sb.delete();
        m_beat = 0;
        m_pkt  = '0;
        m_ovf  = 1'b0;
    endtask

    // Drive one cycle of inputs and advance the reference model; ev/eh describe the expected head.
    task automatic step(input logic v, input logic [DW-1:0] d, input logic r);
        logic pop;
        logic push;
        in_valid = v;
        in_data  = d;
        m_ready  = r;
        @(negedge clk);
        ev   = (sb.size() != 0);
        eh   = ev ? sb[0] : '0;
        pop  = ev && r;
        push = v && ((sb.size() < DEPTH) || pop);
        if (pop) begin
            if (sb[0].last) m_pkt = m_pkt + 16'd1;
            void'(sb.pop_front());
        end
        if (push) sb.push_back(tb_ent_t'{last: (m_beat == PKT_LEN - 1), data: d});
        else if (v) m_ovf = 1'b1;
        if (v) m_beat = (m_beat == PKT_LEN - 1) ? 0 : m_beat + 1;
    endtask

    task automatic do_reset(input logic v);
        in_valid = v;
        in_data  = 32'hBAD0_0000;
        m_ready  = 1'b0;
        rst      = 1'b1;
        tick();
        rst      = 1'b0;
        in_valid = 1'b0;
        model_clear();
    endtask

    task automatic test_reset();
        vec_cnt++; if (m_valid !== 1'b0) begin err_cnt++; $display("FAIL reset_m_valid: got %0b want 0", m_valid); end
        vec_cnt++; if (m_data !== '0) begin err_cnt++; $display("FAIL reset_m_data: got %h want 0", m_data); end
        vec_cnt++; if (m_last !== 1'b0) begin err_cnt++; $display("FAIL reset_m_last: got %0b want 0", m_last); end
        vec_cnt++; if (level !== 4'd0) begin err_cnt++; $display("FAIL reset_level: got %0d want 0", level); end
        vec_cnt++; if (pkt_cnt !== 16'd0) begin err_cnt++; $display("FAIL reset_pkt_cnt: got %0d want 0", pkt_cnt); end
        vec_cnt++; if (overflow !== 1'b0) begin err_cnt++; $display("FAIL reset_overflow: got %0b want 0", overflow); end
    endtask

    task automatic test_single_packet();
        for (int i = 0; i < 10 + 4; i++) begin
            if (i < 10) step(1'b1, DW'(i + 1), 1'b1);
            else        step(1'b0, '0, 1'b1);
            vec_cnt++;
            if (m_valid !== ev || (ev && (m_data !== eh.data || m_last !== eh.last))) begin
                err_cnt++;
                $display("FAIL single_stream: got v=%0b d=%h l=%0b want v=%0b d=%h l=%0b",
                         m_valid, m_data, m_last, ev, eh.data, eh.last);
            end
            tick();
        end
        vec_cnt++; if (pkt_cnt !== 16'd1) begin err_cnt++; $display("FAIL single_pkt_cnt: got %0d want 1", pkt_cnt); end
        vec_cnt++; if (overflow !== 1'b0) begin err_cnt++; $display("FAIL single_overflow: got %0b want 0", overflow); end
    endtask

    task automatic test_backpressure();
        int dut_pops;
        for (int i = 0; i < 9; i++) begin
            step(1'b1, (i < 8) ? DW'(32'h100 + i) : 32'hDEAD, 1'b0);
            vec_cnt++;
            if (m_valid !== ev || (ev && (m_data !== eh.data || m_last !== eh.last))) begin
                err_cnt++;
                $display("FAIL bp_fill: got v=%0b d=%h l=%0b want v=%0b d=%h l=%0b",
                         m_valid, m_data, m_last, ev, eh.data, eh.last);
            end
            tick();
            if (i == 7) begin
                vec_cnt++; if (level !== 4'd8) begin err_cnt++; $display("FAIL bp_level_full: got %0d want 8", level); end
                vec_cnt++; if (m_data !== 32'h100) begin err_cnt++; $display("FAIL bp_head: got %h want 100", m_data); end
            end
        end
        vec_cnt++; if (overflow !== 1'b1) begin err_cnt++; $display("FAIL bp_overflow: got %0b want 1", overflow); end
        vec_cnt++; if (level !== 4'd8) begin err_cnt++; $display("FAIL bp_level_after_drop: got %0d want 8", level); end
        dut_pops = 0;
        for (int k = 0; k < DEPTH + 4; k++) begin
            step(1'b0, '0, 1'b1);
            if (m_valid) dut_pops++;
            vec_cnt++;
            if (m_valid !== ev || (ev && (m_data !== eh.data || m_last !== eh.last)) || (m_valid && m_data === 32'hDEAD)) begin
                err_cnt++;
                $display("FAIL bp_drain: got v=%0b d=%h l=%0b want v=%0b d=%h l=%0b",
                         m_valid, m_data, m_last, ev, eh.data, eh.last);
            end
            tick();
        end
        vec_cnt++; if (dut_pops !== 8) begin err_cnt++; $display("FAIL bp_drain_count: got %0d want 8", dut_pops); end
        vec_cnt++; if (pkt_cnt !== m_pkt) begin err_cnt++; $display("FAIL bp_pkt_cnt: got %0d want %0d", pkt_cnt, m_pkt); end
    endtask

    task automatic test_full_push_pop();
        do_reset(1'b0);
        for (int i = 0; i < 9 + DEPTH + 4; i++) begin
            if (i < 8)       step(1'b1, DW'(32'h200 + i), 1'b0);
            else if (i == 8) step(1'b1, 32'h2FF, 1'b1);
            else             step(1'b0, '0, 1'b1);
            vec_cnt++;
            if (m_valid !== ev || (ev && (m_data !== eh.data || m_last !== eh.last))) begin
                err_cnt++;
                $display("FAIL fullpp_stream: got v=%0b d=%h l=%0b want v=%0b d=%h l=%0b",
                         m_valid, m_data, m_last, ev, eh.data, eh.last);
            end
            tick();
            if (i == 8) begin
                vec_cnt++; if (level !== 4'd8) begin err_cnt++; $display("FAIL fullpp_level: got %0d want 8", level); end
                vec_cnt++; if (overflow !== 1'b0) begin err_cnt++; $display("FAIL fullpp_overflow: got %0b want 0", overflow); end
                vec_cnt++; if (m_data !== 32'h201) begin err_cnt++; $display("FAIL fullpp_next_head: got %h want 201", m_data); end
            end
        end
    endtask

    task automatic test_drop_align();
        logic seen_last20;
        seen_last20 = 1'b0;
        do_reset(1'b0);
        for (int i = 1; i <= 20 + DEPTH + 4; i++) begin
            if (i <= 11)      step(1'b1, DW'(i), 1'b0);
            else if (i <= 20) step(1'b1, DW'(i), 1'b1);
            else              step(1'b0, '0, 1'b1);
            if (m_valid && m_ready && m_data === 32'd20 && m_last === 1'b1) seen_last20 = 1'b1;
            vec_cnt++;
            if (m_valid !== ev || (ev && (m_data !== eh.data || m_last !== eh.last))) begin
                err_cnt++;
                $display("FAIL drop_stream: got v=%0b d=%h l=%0b want v=%0b d=%h l=%0b",
                         m_valid, m_data, m_last, ev, eh.data, eh.last);
            end
            tick();
        end
        vec_cnt++; if (seen_last20 !== 1'b1) begin err_cnt++; $display("FAIL drop_last_on_20: got %0b want 1", seen_last20); end
        vec_cnt++; if (pkt_cnt !== 16'd1) begin err_cnt++; $display("FAIL drop_pkt_cnt: got %0d want 1", pkt_cnt); end
        vec_cnt++; if (overflow !== 1'b1) begin err_cnt++; $display("FAIL drop_overflow: got %0b want 1", overflow); end
    endtask

    task automatic test_reset_mid_drain();
        do_reset(1'b0);
        for (int i = 1; i <= 13; i++) begin
            if (i <= 8)       step(1'b1, DW'(32'h400 + i), 1'b0);
            else if (i <= 10) step(1'b1, DW'(32'h400 + i), 1'b1);
            else              step(1'b0, '0, 1'b1);
            vec_cnt++;
            if (m_valid !== ev || (ev && (m_data !== eh.data || m_last !== eh.last))) begin
                err_cnt++;
                $display("FAIL rmd_pre: got v=%0b d=%h l=%0b want v=%0b d=%h l=%0b",
                         m_valid, m_data, m_last, ev, eh.data, eh.last);
            end
            tick();
        end
        do_reset(1'b1);
        vec_cnt++; if (m_valid !== 1'b0) begin err_cnt++; $display("FAIL rmd_m_valid: got %0b want 0", m_valid); end
        vec_cnt++; if (level !== 4'd0) begin err_cnt++; $display("FAIL rmd_level: got %0d want 0", level); end
        vec_cnt++; if (pkt_cnt !== 16'd0) begin err_cnt++; $display("FAIL rmd_pkt_cnt: got %0d want 0", pkt_cnt); end
        vec_cnt++; if (overflow !== 1'b0) begin err_cnt++; $display("FAIL rmd_overflow: got %0b want 0", overflow); end
        for (int i = 1; i <= 10 + 4; i++) begin
            if (i <= 10) step(1'b1, DW'(32'h300 + i), 1'b1);
            else         step(1'b0, '0, 1'b1);
            vec_cnt++;
            if (m_valid !== ev || (ev && (m_data !== eh.data || m_last !== eh.last))) begin
                err_cnt++;
                $display("FAIL rmd_post: got v=%0b d=%h l=%0b want v=%0b d=%h l=%0b",
                         m_valid, m_data, m_last, ev, eh.data, eh.last);
            end
            tick();
        end
        vec_cnt++; if (pkt_cnt !== 16'd1) begin err_cnt++; $display("FAIL rmd_pkt_cnt_after: got %0d want 1", pkt_cnt); end
    endtask

    task automatic test_counter_wrap();
        force dut.pkt_cnt = 16'hFFFF;
        #1;
        release dut.pkt_cnt;
        m_pkt = 16'hFFFF;
        vec_cnt++; if (pkt_cnt !== 16'hFFFF) begin err_cnt++; $display("FAIL wrap_preload: got %h want ffff", pkt_cnt); end
        for (int i = 1; i <= 10 + 4; i++) begin
            if (i <= 10) step(1'b1, DW'(32'h500 + i), 1'b1);
            else         step(1'b0, '0, 1'b1);
            vec_cnt++;
            if (m_valid !== ev || (ev && (m_data !== eh.data || m_last !== eh.last))) begin
                err_cnt++;
                $display("FAIL wrap_stream: got v=%0b d=%h l=%0b want v=%0b d=%h l=%0b",
                         m_valid, m_data, m_last, ev, eh.data, eh.last);
            end
            tick();
        end
        vec_cnt++; if (pkt_cnt !== 16'h0000) begin err_cnt++; $display("FAIL wrap_pkt_cnt: got %h want 0000", pkt_cnt); end
    endtask

    initial begin
        vec_cnt  = 0;
        err_cnt  = 0;
        rst      = 1'b1;
        in_valid = 1'b0;
        in_data  = '0;
        m_ready  = 1'b0;
        model_clear();
        tick();
        tick();
        rst = 1'b0;
        test_reset();
        test_single_packet();
        test_backpressure();
        test_full_push_pop();
        test_drop_align();
        test_reset_mid_drain();
        test_counter_wrap();
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

endmodule

// File: doc/conv_out_collector.md
# conv_out_collector

Result-side companion to the `con` convolution core. It samples the core's `out_reg` on every `valid` pulse and tags each result with its position in a fixed-length packet. Results are buffered in a small FIFO and presented downstream on a valid/ready stream with an end-of-packet marker. It also counts completed packets and flags dropped results.

## Interface
Parameters:
- `OUT_W`, 32: width of one core result (`out_reg`).
- `DEPTH`, 8: FIFO entries; must be a power of two, at least 2.
- `PKT_LEN`, 10: results per packet, matching the ten-beat input packet driven into the core.

Ports:
- `clk`, in, 1: single clock; all logic on the rising edge.
- `rst`, in, 1: reset, synchronous and active-high.
- `in_valid`, in, 1: the core's `valid`; one result per high cycle.
- `in_data`, in, `OUT_W`: the core's `out_reg`.
- `m_valid`, out, 1: downstream entry available.
- `m_ready`, in, 1: downstream accepts.
- `m_data`, out, `OUT_W`: head entry data.
- `m_last`, out, 1: head entry is beat `PKT_LEN-1` of its packet.
- `level`, out, `$clog2(DEPTH)+1`: current FIFO occupancy.
- `pkt_cnt`, out, 16: packets fully popped; wraps modulo 2^16.
- `overflow`, out, 1: sticky; a result was dropped.

## Operation
- **Beat counter `beat`** (0..`PKT_LEN-1`):
  - Advances on every `in_valid`, whether the result is stored or dropped.
  - Wraps to 0 after `PKT_LEN-1`.
  - The stored tag is `last = (beat == PKT_LEN-1)`.
- **Push:** occurs when `in_valid && (!full || pop)`.
- **Pop:** occurs when `m_valid && m_ready`.
- **Simultaneous push and pop:**
  - When full, both succeed and `level` is unchanged.
  - When empty, push only; there is no bypass.
- **Drop:** occurs when `in_valid && full && !pop`.
  - Data is discarded and `overflow` is set.
  - `overflow` stays set until `rst`.
- **Packet count:** `pkt_cnt` increments on a pop whose entry has `last=1`. It wraps from 0xFFFF to 0.
- **Output stream:**
  - `m_data` and `m_last` are driven from the head entry (registered RAM read or registered head).
  - Both hold stable while `m_valid && !m_ready`.
- **Pointers:** read and write pointers are `$clog2(DEPTH)` bits and wrap naturally.
  - `full = (level == DEPTH)`.
  - `empty = (level == 0)`.
- **FSM** (tracks the packet phase for the beat tag):
  - `IDLE`: `beat=0`. Moves to `FILL` on the first `in_valid` when `PKT_LEN>1`; otherwise stays in `IDLE`.
  - `FILL`: returns to `IDLE` when `in_valid` arrives with `beat==PKT_LEN-1`.
- **Reset:**
  - Asserting `rst` mid-packet or mid-drain flushes the FIFO, zeroes `beat` and `pkt_cnt`, clears `overflow`, and returns the FSM to `IDLE`.
  - Any `in_valid` in the reset cycle is ignored.

## Timing
- Reset values: `m_valid=0`, `m_data=0`, `m_last=0`, `level=0`, `pkt_cnt=0`, `overflow=0`.
- **Latency:** `in_valid` sampled at edge N gives `m_valid=1` after edge N, with `level` incremented. That is one cycle of latency.
- **Throughput:** one push and one pop per cycle.
- **Pop side effects:** after the popping edge, `level`, `m_data` and `m_last` reflect the next entry. `pkt_cnt` updates on that same edge.
- **Overflow timing:** `overflow` rises after the edge on which the drop occurs.
- **`m_valid` discipline:** once asserted, `m_valid` deasserts only after a pop empties the FIFO, or on reset.

## Structure
- Shared package `conv_core_pkg` holds:
  - `localparam OUT_W_DEF=32`, `PKT_LEN_DEF=10`;
  - `typedef enum logic {IDLE, FILL} coll_state_t`;
  - a helper type `typedef struct packed {logic last; logic [OUT_W-1:0] data;}`. Because this struct depends on `OUT_W`, it is declared inside the module.
- Sub-module `conv_out_fifo`: parameterised synchronous FIFO with `push`, `pop`, `din`, `dout`, `full`, `empty` and `level`. The top level adds the beat tagging, FSM, counters and overflow flag.

## Test plan
- **Single packet, `m_ready=1`:** 10 consecutive `in_valid` with data 1..10.
  - Required: 10 pops in order 1..10.
  - `m_last` is high only on data 10.
  - `pkt_cnt=1`, `overflow=0`, each beat one cycle after its input.
- **Backpressure fill:** `m_ready=0` and 8 results pushed.
  - Required: `level=8` and `m_data` holds the first value.
  - A 9th `in_valid` (data 0xDEAD) is dropped and `overflow=1`.
  - After releasing `m_ready`, exactly 8 entries drain and 0xDEAD is absent.
- **Full with simultaneous push/pop:** `level=8`, `m_ready=1` and `in_valid=1` in the same cycle.
  - Required: `level` stays 8, `overflow` stays 0, and the new data appears in order.
- **Drop keeps alignment:** 3 drops occur in packet 1.
  - Required: `m_last` still lands on the entry that was input beat 20 (the packet 2 boundary).
  - `pkt_cnt` reaches the expected value.
- **Reset mid-drain:** after 5 of 10 entries pop, `rst` is held 1 cycle.
  - Required: `m_valid=0`, `level=0`, `pkt_cnt=0`, `overflow=0`.
  - The next 10 inputs form a clean packet with `m_last` on beat 10.
- **Counter wrap:** preload by running 65536 packets, or force `pkt_cnt=0xFFFF`.
  - Required: the next completed packet gives `pkt_cnt=0`.
